// File: rtl/key_event_queue.sv
// key_event_queue: FWFT circular queue of {make, code} key events with saturating overflow count.
// Define KEY_EVT_REPEAT_FILTER_EN to drop typematic repeats of keys already held.
module key_event_queue #(
    parameter int DEPTH = 8,
    parameter int OVF_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_valid,
    input  logic [8:0]               last_change,
    input  logic [511:0]             key_down,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [8:0]               evt_code,
    output logic                     evt_make,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [OVF_W-1:0]         ovf_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_nxt;
    logic          make, discard, accept, pop, push, drop;

    assign make = key_down[last_change];

`ifdef KEY_EVT_REPEAT_FILTER_EN
    logic [511:0] held;
    assign discard = make && held[last_change];
    // held tracks only what actually entered the queue
    always_ff @(posedge clk) begin
        if (!rst)
            held <= '0;
        else if (push)
            held[last_change] <= make;
    end
`else
    assign discard = 1'b0;
`endif

    assign accept    = key_valid && !discard;
    assign pop       = !empty && evt_ready;
    assign push      = accept && (!full || pop);
    assign drop      = accept && full && !pop;
    assign evt_valid = !empty;
    assign evt_code  = mem[rd_ptr][8:0];
    assign evt_make  = mem[rd_ptr][9];

    always_comb begin
        count_nxt = (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            ovf_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {make, last_change};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= count_nxt == (AW+1)'(DEPTH);
            empty <= count_nxt == '0;
            if (drop && ovf_cnt != '1)
                ovf_cnt <= ovf_cnt + 1'b1;
        end
    end
endmodule
